// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage and its register-write scoreboard.
package wb_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned REG_AW      = 4;
    localparam int unsigned NUM_REGS    = 16;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned NUM_TRACKED = 15;

    localparam logic [REG_AW-1:0] PC_REG = 4'd15;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // R15 belongs to the PC path and never takes part in register writeback.
    function automatic logic is_gpr(input logic [REG_AW-1:0] a);
        return a != PC_REG;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters; raises an ID stall while a source
// register still has an issued, unretired write.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_issue,
    input  logic [REG_AW-1:0] i_issue_a,
    input  logic              i_retire,
    input  logic [REG_AW-1:0] i_retire_a,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_a1,
    input  logic [REG_AW-1:0] i_a2,
    input  logic              i_use_a2,
    output logic              o_stall_c,
    output logic              o_err
);

    logic [CNT_W-1:0]    r_cnt [NUM_TRACKED];
    logic [CNT_W-1:0]    w_cnt_nxt [NUM_TRACKED];
    logic                r_err;
    logic                w_err_set;
    logic [NUM_REGS-1:0] w_busy;

    // Busy map over the full register space; R15 is never busy.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NUM_TRACKED; i++) begin
            w_busy[i] = (r_cnt[i] != CNT_ZERO);
        end
    end

    assign o_stall_c = i_id_valid & (w_busy[i_a1] | (i_use_a2 & w_busy[i_a2]));

    // Issue and retire to the same register cancel; otherwise each saturates.
    always_comb begin
        w_err_set = 1'b0;
        for (int i = 0; i < NUM_TRACKED; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end
        for (int i = 0; i < NUM_TRACKED; i++) begin
            logic w_inc;
            logic w_dec;
            w_inc = i_issue  & (i_issue_a  == REG_AW'(i));
            w_dec = i_retire & (i_retire_a == REG_AW'(i));
            if (w_inc && !w_dec) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end else if (w_dec && !w_inc) begin
                if (r_cnt[i] == CNT_ZERO) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_TRACKED; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TRACKED; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_err <= r_err | w_err_set;
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: MEM/WB pipe register, result mux, R15 write filter and
// the pending-write scoreboard that stalls ID on read-after-write hazards.
module stage_wb
    import wb_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              mem_valid_i,
    input  logic              RF_WE_i,
    input  logic [REG_AW-1:0] A3_i,
    input  logic [N-1:0]      ALUResult_i,
    input  logic [N-1:0]      ReadData_i,
    input  logic              WBSelect_i,
    input  logic              id_valid_i,
    input  logic              id_we_i,
    input  logic [REG_AW-1:0] id_A3_i,
    input  logic [REG_AW-1:0] A1_i,
    input  logic [REG_AW-1:0] A2_i,
    input  logic              use_A2_i,
    output logic              WE3_o,
    output logic [REG_AW-1:0] A3_o,
    output logic [N-1:0]      WD3_o,
    output logic              stall_id_o,
    output logic              sb_err_o
);

    logic              r_we3;
    logic [REG_AW-1:0] r_a3;
    logic [N-1:0]      r_wd3;
    logic              w_wb_we;
    logic [N-1:0]      w_wb_data;
    logic              w_stall;
    logic              w_issue;

    assign w_wb_we   = mem_valid_i & RF_WE_i & is_gpr(A3_i);
    assign w_wb_data = (WBSelect_i == WB_SEL_MEM) ? ReadData_i : ALUResult_i;

    // MEM/WB pipe register; a reset edge discards any write in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_wb_we;
            r_a3  <= A3_i;
            r_wd3 <= w_wb_data;
        end
    end

    assign w_issue = id_valid_i & id_we_i & ~w_stall & is_gpr(id_A3_i);

    wb_scoreboard u_scoreboard (
        .CLK        (CLK),
        .RST        (RST),
        .i_issue    (w_issue),
        .i_issue_a  (id_A3_i),
        .i_retire   (r_we3),
        .i_retire_a (r_a3),
        .i_id_valid (id_valid_i),
        .i_a1       (A1_i),
        .i_a2       (A2_i),
        .i_use_a2   (use_A2_i),
        .o_stall_c  (w_stall),
        .o_err      (sb_err_o)
    );

    assign WE3_o      = r_we3;
    assign A3_o       = r_a3;
    assign WD3_o      = r_wd3;
    assign stall_id_o = w_stall;

endmodule

// File: tb/tb_stage_wb.sv
// Directed and random checks of stage_wb against a cycle-level model of the
// writeback register and per-register pending-write counts.
module tb_stage_wb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        mem_valid_i, RF_WE_i, WBSelect_i;
    logic [3:0]  A3_i, id_A3_i, A1_i, A2_i;
    logic [31:0] ALUResult_i, ReadData_i;
    logic        id_valid_i, id_we_i, use_A2_i;
    logic        WE3_o;
    logic [3:0]  A3_o;
    logic [31:0] WD3_o;
    logic        stall_id_o, sb_err_o;

    int checks   = 0;
    int failures = 0;

    int          m_cnt [16];
    logic        m_err;
    logic        m_we;
    logic [3:0]  m_a3;
    logic [31:0] m_wd;
    bit          m_known = 0;
    logic        last_stall;
    int          stall_cycles;

    stage_wb dut (
        .CLK(CLK), .RST(RST),
        .mem_valid_i(mem_valid_i), .RF_WE_i(RF_WE_i), .A3_i(A3_i),
        .ALUResult_i(ALUResult_i), .ReadData_i(ReadData_i), .WBSelect_i(WBSelect_i),
        .id_valid_i(id_valid_i), .id_we_i(id_we_i), .id_A3_i(id_A3_i),
        .A1_i(A1_i), .A2_i(A2_i), .use_A2_i(use_A2_i),
        .WE3_o(WE3_o), .A3_o(A3_o), .WD3_o(WD3_o),
        .stall_id_o(stall_id_o), .sb_err_o(sb_err_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RST = 0; mem_valid_i = 0; RF_WE_i = 0; A3_i = 0;
        ALUResult_i = 0; ReadData_i = 0; WBSelect_i = 0;
        id_valid_i = 0; id_we_i = 0; id_A3_i = 0; A1_i = 0; A2_i = 0; use_A2_i = 0;
    endtask

    task automatic rand_inputs();
        mem_valid_i = 1'($urandom); RF_WE_i = 1'($urandom); A3_i = 4'($urandom);
        ALUResult_i = $urandom; ReadData_i = $urandom; WBSelect_i = 1'($urandom);
        id_valid_i = 1'($urandom); id_we_i = 1'($urandom); id_A3_i = 4'($urandom);
        A1_i = 4'($urandom); A2_i = 4'($urandom); use_A2_i = 1'($urandom);
    endtask

    task automatic mem_write(input logic [3:0] a, input logic [31:0] d);
        mem_valid_i = 1; RF_WE_i = 1; A3_i = a; ALUResult_i = d; WBSelect_i = 0;
    endtask

    task automatic issue(input logic [3:0] a);
        id_valid_i = 1; id_we_i = 1; id_A3_i = a; A1_i = 0; A2_i = 0; use_A2_i = 0;
    endtask

    // One clock: check the combinational stall, step the model, check registers.
    task automatic cycle();
        logic exp_stall, iss, ret;
        #1;
        exp_stall = id_valid_i && ((A1_i != 15 && m_cnt[A1_i] != 0) ||
                                   (use_A2_i && A2_i != 15 && m_cnt[A2_i] != 0));
        if (m_known) chk("stall", 32'(stall_id_o), 32'(exp_stall));
        last_stall = stall_id_o;
        iss = id_valid_i && id_we_i && !exp_stall && id_A3_i != 15;
        ret = m_we;
        @(posedge CLK);
        if (RST) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_err = 0; m_we = 0; m_a3 = 0; m_wd = 0;
            m_known = 1;
        end else begin
            if (!(iss && ret && id_A3_i == m_a3)) begin
                if (iss) begin
                    if (m_cnt[id_A3_i] == 3) m_err = 1;
                    else m_cnt[id_A3_i] += 1;
                end
                if (ret) begin
                    if (m_cnt[m_a3] == 0) m_err = 1;
                    else m_cnt[m_a3] -= 1;
                end
            end
            m_we = mem_valid_i && RF_WE_i && A3_i != 15;
            m_a3 = A3_i;
            m_wd = WBSelect_i ? ReadData_i : ALUResult_i;
        end
        #1;
        if (m_known) begin
            chk("WE3", 32'(WE3_o), 32'(m_we));
            chk("A3", 32'(A3_o), 32'(m_a3));
            chk("WD3", WD3_o, m_wd);
            chk("sb_err", 32'(sb_err_o), 32'(m_err));
        end
    endtask

    task automatic do_reset();
        idle(); RST = 1; cycle(); RST = 0;
    endtask

    initial begin
        idle();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_err = 0; m_we = 0; m_a3 = 0; m_wd = 0;

        // Reset with random inputs
        rand_inputs(); RST = 1; cycle();
        rand_inputs(); RST = 1; cycle();
        chk("rst_we3", 32'(WE3_o), 32'd0);
        chk("rst_wd3", WD3_o, 32'd0);
        idle(); cycle();
        chk("rst_stall", 32'(last_stall), 32'd0);

        // ALU and load writeback
        mem_write(4'd5, 32'h1234); cycle();
        chk("alu_wd", WD3_o, 32'h1234); chk("alu_a3", 32'(A3_o), 32'd5);
        mem_write(4'd5, 32'h1234); WBSelect_i = 1; ReadData_i = 32'hCAFE; cycle();
        chk("ld_wd", WD3_o, 32'hCAFE);

        // R15 filter on write and issue
        do_reset();
        mem_write(4'd15, 32'hDEAD); issue(4'd15); cycle();
        chk("r15_we3", 32'(WE3_o), 32'd0);
        idle();
        for (int r = 0; r < 15; r++) begin
            id_valid_i = 1; A1_i = 4'(r); cycle();
        end

        // RAW stall on A1: producer issues, dependent stalls 3 cycles
        do_reset();
        stall_cycles = 0;
        issue(4'd3); cycle();
        idle(); id_valid_i = 1; A1_i = 3;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) mem_write(4'd3, 32'h33);
            else begin mem_valid_i = 0; RF_WE_i = 0; end
            cycle();
            if (last_stall) stall_cycles++;
        end
        chk("raw_stall_cycles", 32'(stall_cycles), 32'd3);

        // Same with A2 unused: no stall
        do_reset();
        stall_cycles = 0;
        issue(4'd3); cycle();
        idle(); id_valid_i = 1; A1_i = 0; A2_i = 3; use_A2_i = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) mem_write(4'd3, 32'h33);
            else begin mem_valid_i = 0; RF_WE_i = 0; end
            cycle();
            if (last_stall) stall_cycles++;
        end
        chk("a2_unused_stall", 32'(stall_cycles), 32'd0);

        // Issue and retire of R4 in the same cycle
        do_reset();
        issue(4'd4); cycle();
        idle(); cycle();
        mem_write(4'd4, 32'h44); cycle();
        idle(); issue(4'd4); cycle();
        idle(); cycle();
        mem_write(4'd4, 32'h45); cycle();
        idle(); id_valid_i = 1; A1_i = 4; cycle();
        chk("same_cycle_stall", 32'(last_stall), 32'd1);
        cycle();
        chk("same_cycle_free", 32'(last_stall), 32'd0);

        // Three back-to-back writes to R4: stall until the third retires
        do_reset();
        stall_cycles = 0;
        for (int c = 0; c < 7; c++) begin
            idle();
            if (c < 3) issue(4'd4);
            else begin id_valid_i = 1; A1_i = 4; end
            if (c >= 2 && c <= 4) mem_write(4'd4, 32'(c));
            cycle();
            if (last_stall) stall_cycles++;
        end
        chk("triple_stall_cycles", 32'(stall_cycles), 32'd3);

        // Fourth issue at count 3 sets the sticky error
        do_reset();
        for (int c = 0; c < 4; c++) begin issue(4'd4); cycle(); end
        chk("overflow_err", 32'(sb_err_o), 32'd1);
        idle(); cycle(); cycle();
        chk("err_sticky", 32'(sb_err_o), 32'd1);
        do_reset();
        chk("err_cleared", 32'(sb_err_o), 32'd0);

        // Reset mid-flight with two writes pending on R7
        issue(4'd7); cycle();
        issue(4'd7); cycle();
        idle(); id_valid_i = 1; A1_i = 7; cycle();
        chk("pre_rst_stall", 32'(last_stall), 32'd1);
        mem_write(4'd7, 32'h77); RST = 1; cycle();
        chk("rst_mid_we3", 32'(WE3_o), 32'd0);
        idle(); id_valid_i = 1; A1_i = 7; cycle();
        chk("rst_mid_stall", 32'(last_stall), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rand_inputs();
            RST = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
